// File: rtl/ht1632_pkg.sv
// ============================================================================
// Module      : ht1632_pkg
// Description : Shared constants, FSM encoding and field widths for ht1632_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ht1632_pkg;

  localparam int c_RAM_DEPTH = 96;

  localparam logic [2:0] c_ID_CMD   = 3'b100;
  localparam logic [2:0] c_ID_WRITE = 3'b101;

  localparam logic [7:0] c_CMD_SYS_DIS   = 8'h00;
  localparam logic [7:0] c_CMD_SYS_EN    = 8'h01;
  localparam logic [7:0] c_CMD_LED_OFF   = 8'h02;
  localparam logic [7:0] c_CMD_LED_ON    = 8'h03;
  localparam logic [7:0] c_CMD_BLINK_OFF = 8'h08;
  localparam logic [7:0] c_CMD_BLINK_ON  = 8'h09;
  localparam logic [3:0] c_CMD_PWM_HI    = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ID   = 3'd1,
    S_CMD  = 3'd2,
    S_ADDR = 3'd3,
    S_DATA = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Number of serial bits making up one field in each receiving state.
  function automatic logic [3:0] field_len(input state_t s);
    case (s)
      S_ID:    return 4'd3;
      S_CMD:   return 4'd9;
      S_ADDR:  return 4'd7;
      S_DATA:  return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ht1632_edge_sync.sv
// ============================================================================
// Module      : ht1632_edge_sync
// Description : Multi-flop synchronizer with rising/falling edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ht1632_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int c_FILL = SYNC_STAGES + 1;
  localparam int c_CW   = $clog2(c_FILL + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [c_CW-1:0]        r_fill;
  logic                   w_filled;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) r_sync <= RESET_VAL;
        else     r_sync <= i_async;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) r_sync <= {SYNC_STAGES{RESET_VAL}};
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
    end
  endgenerate

  // Edges are suppressed until the chain holds only real samples, so a line
  // already active when reset releases never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= RESET_VAL;
      r_fill <= '0;
    end else begin
      r_prev <= r_sync[SYNC_STAGES-1];
      if (!w_filled) r_fill <= r_fill + c_CW'(1);
    end
  end

  assign w_filled = (r_fill == c_CW'(c_FILL));
  assign o_level  = r_sync[SYNC_STAGES-1];
  assign o_rise   = w_filled &  o_level & ~r_prev;
  assign o_fall   = w_filled & ~o_level &  r_prev;

endmodule

`default_nettype wire

// File: rtl/ht1632_rx.sv
// ============================================================================
// Module      : ht1632_rx
// Description : HT1632 serial-bus receiver: command decode and display RAM.
//               Define HT1632_RX_STATUS_EN to track status from commands.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ht1632_rx
  import ht1632_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RAM_DEPTH   = c_RAM_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       write,
  input  logic       data,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       ram_wr_en,
  output logic [6:0] ram_wr_addr,
  output logic [3:0] ram_wr_nibble,
  input  logic [6:0] rd_addr,
  output logic [3:0] rd_data,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic       sys_en,
  output logic       led_on,
  output logic       blink_on,
  output logic [3:0] pwm_level
);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_wr_rise, w_wr_level_unused, w_wr_fall_unused;
  logic w_data_lvl, w_data_rise_unused, w_data_fall_unused;

  ht1632_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_async(cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  ht1632_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wr (
    .clk(clk), .rst(rst), .i_async(write),
    .o_level(w_wr_level_unused), .o_rise(w_wr_rise), .o_fall(w_wr_fall_unused)
  );
  ht1632_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst(rst), .i_async(data),
    .o_level(w_data_lvl), .o_rise(w_data_rise_unused), .o_fall(w_data_fall_unused)
  );

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [6:0] r_ptr;
  logic       r_cmd_valid, r_ram_wr_en, r_busy, r_frame_done, r_frame_err;
  logic [7:0] r_cmd_code;
  logic [6:0] r_ram_wr_addr;
  logic [3:0] r_ram_wr_nibble;
  logic [3:0] r_rd_data;
  logic [3:0] r_mem [RAM_DEPTH];

  logic       w_take, w_field_done, w_id_bad;
  logic [8:0] w_shift_next;
  logic [3:0] w_cnt_inc, w_cnt_after;
  logic [6:0] w_addr_wrap, w_ptr_inc;

  // A bit arriving in the same clk as cs rising still belongs to the frame.
  assign w_take       = w_wr_rise && (!w_cs_lvl || w_cs_rise) &&
                        (r_state inside {S_ID, S_CMD, S_ADDR, S_DATA});
  assign w_shift_next = {r_shift, w_data_lvl};
  assign w_cnt_inc    = r_cnt + 4'd1;
  assign w_field_done = w_take && (w_cnt_inc == field_len(r_state));
  assign w_cnt_after  = w_take ? (w_field_done ? 4'd0 : w_cnt_inc) : r_cnt;
  assign w_id_bad     = w_field_done && (r_state == S_ID) &&
                        (w_shift_next[2:0] != c_ID_CMD) &&
                        (w_shift_next[2:0] != c_ID_WRITE);
  assign w_addr_wrap  = 7'(32'(w_shift_next[6:0]) % RAM_DEPTH);
  assign w_ptr_inc    = (32'(r_ptr) == RAM_DEPTH - 1) ? 7'd0 : r_ptr + 7'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_shift         <= '0;
      r_ptr           <= '0;
      r_cmd_valid     <= 1'b0;
      r_cmd_code      <= '0;
      r_ram_wr_en     <= 1'b0;
      r_ram_wr_addr   <= '0;
      r_ram_wr_nibble <= '0;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_cmd_valid  <= 1'b0;
      r_ram_wr_en  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_cs_fall) begin
        r_state <= S_ID;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state != S_IDLE) begin
        if (w_take) begin
          r_shift <= w_shift_next[7:0];
          r_cnt   <= w_cnt_after;
          if (w_field_done) begin
            case (r_state)
              S_ID: begin
                if (w_id_bad) begin
                  r_state     <= S_ERR;
                  r_frame_err <= 1'b1;
                end else if (w_shift_next[2:0] == c_ID_CMD) begin
                  r_state <= S_CMD;
                end else begin
                  r_state <= S_ADDR;
                end
              end
              S_CMD: begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= w_shift_next[8:1];
              end
              S_ADDR: begin
                r_ptr   <= w_addr_wrap;
                r_state <= S_DATA;
              end
              S_DATA: begin
                r_ram_wr_en     <= 1'b1;
                r_ram_wr_addr   <= r_ptr;
                r_ram_wr_nibble <= w_shift_next[3:0];
                r_ptr           <= w_ptr_inc;
              end
              default: ;
            endcase
          end
        end
        // A bad ID already raised frame_err; the close stays silent then.
        if (w_cs_rise) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          if (r_state != S_ERR && !w_id_bad) begin
            if (w_cnt_after == 4'd0) r_frame_done <= 1'b1;
            else                     r_frame_err  <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_ram_wr_en) r_mem[r_ram_wr_addr] <= r_ram_wr_nibble;
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_rd_data <= '0;
    else if (32'(rd_addr) < RAM_DEPTH) r_rd_data <= r_mem[rd_addr];
    else                              r_rd_data <= '0;
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_code      = r_cmd_code;
  assign ram_wr_en     = r_ram_wr_en;
  assign ram_wr_addr   = r_ram_wr_addr;
  assign ram_wr_nibble = r_ram_wr_nibble;
  assign rd_data       = r_rd_data;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign frame_err     = r_frame_err;

`ifdef HT1632_RX_STATUS_EN
  logic       r_sys_en, r_led_on, r_blink_on;
  logic [3:0] r_pwm_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sys_en    <= 1'b0;
      r_led_on    <= 1'b0;
      r_blink_on  <= 1'b0;
      r_pwm_level <= '0;
    end else if (r_cmd_valid) begin
      case (r_cmd_code)
        c_CMD_SYS_DIS:   r_sys_en   <= 1'b0;
        c_CMD_SYS_EN:    r_sys_en   <= 1'b1;
        c_CMD_LED_OFF:   r_led_on   <= 1'b0;
        c_CMD_LED_ON:    r_led_on   <= 1'b1;
        c_CMD_BLINK_OFF: r_blink_on <= 1'b0;
        c_CMD_BLINK_ON:  r_blink_on <= 1'b1;
        default: begin
          if (r_cmd_code[7:4] == c_CMD_PWM_HI) r_pwm_level <= r_cmd_code[3:0];
        end
      endcase
    end
  end

  assign sys_en    = r_sys_en;
  assign led_on    = r_led_on;
  assign blink_on  = r_blink_on;
  assign pwm_level = r_pwm_level;
`else
  assign sys_en    = 1'b0;
  assign led_on    = 1'b0;
  assign blink_on  = 1'b0;
  assign pwm_level = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ht1632_rx.sv
// ============================================================================
// Module      : tb_ht1632_rx
// Description : Self-checking bench for ht1632_rx with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ht1632_rx;

  logic       clk = 1'b0;
  logic       rst, cs, write, data;
  logic [6:0] rd_addr;
  logic       cmd_valid, ram_wr_en, busy, frame_done, frame_err;
  logic [7:0] cmd_code;
  logic [6:0] ram_wr_addr;
  logic [3:0] ram_wr_nibble, rd_data, pwm_level;
  logic       sys_en, led_on, blink_on;

  always #5 clk = ~clk;

  ht1632_rx dut (
    .clk(clk), .rst(rst), .cs(cs), .write(write), .data(data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_nibble(ram_wr_nibble),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .sys_en(sys_en), .led_on(led_on), .blink_on(blink_on), .pwm_level(pwm_level)
  );

  typedef struct {int addr; int nib;} wr_t;

  int  checks = 0, failures = 0;
  int  exp_cmd[$];
  wr_t exp_wr[$];
  int  exp_end[$];
  int  mem_m[128];
  bit  known[128];
  int  m_sys = 0, m_led = 0, m_blink = 0, m_pwm = 0;
  int  cnt_cmd = 0, cnt_wr = 0, cnt_done = 0, cnt_err = 0;
  int  b_cmd, b_wr, b_done, b_err;
  bit  fbits[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model: whole frame at once ----------------
  function automatic int field(input int s, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(fbits[s + i]);
    return v;
  endfunction

  task automatic push_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) fbits.push_back(bit'((v >> i) & 1));
  endtask

  task automatic apply_status(input int code);
`ifdef HT1632_RX_STATUS_EN
    case (code)
      'h00: m_sys = 0;
      'h01: m_sys = 1;
      'h02: m_led = 0;
      'h03: m_led = 1;
      'h08: m_blink = 0;
      'h09: m_blink = 1;
      default: if ((code >> 4) == 'hA) m_pwm = code & 'hF;
    endcase
`else
    if (code < 0) m_sys = 0;
`endif
  endtask

  task automatic model_frame();
    int  n, rest, id, addr;
    wr_t w;
    n = fbits.size();
    if (n < 3) begin
      exp_end.push_back(int'(n > 0));
      return;
    end
    id   = field(0, 3);
    rest = n - 3;
    if (id == 4) begin
      for (int i = 0; i < rest / 9; i++) begin
        exp_cmd.push_back(field(3 + 9 * i, 8));
        apply_status(field(3 + 9 * i, 8));
      end
      exp_end.push_back(int'(rest % 9 != 0));
    end else if (id == 5) begin
      if (rest < 7) begin
        exp_end.push_back(int'(rest > 0));
      end else begin
        addr = field(3, 7) % 96;
        for (int i = 0; i < (rest - 7) / 4; i++) begin
          w.addr = addr;
          w.nib  = field(10 + 4 * i, 4);
          exp_wr.push_back(w);
          addr = (addr + 1) % 96;
        end
        exp_end.push_back(int'((rest - 7) % 4 != 0));
      end
    end else begin
      exp_end.push_back(1);
    end
  endtask

  // ---------------- compare process ----------------
  bit  rd_pend = 0;
  int  rd_exp;
  int  e_code, e_end;
  wr_t e_wr;

  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 0;
    end else begin
      if (rd_pend) chk("rd_data", int'(rd_data), rd_exp);
      rd_pend = known[rd_addr];
      rd_exp  = mem_m[rd_addr];
      if (cmd_valid) begin
        cnt_cmd++;
        if (exp_cmd.size() == 0) chk("cmd_valid_unexpected", int'(cmd_valid), 0);
        else begin
          e_code = exp_cmd.pop_front();
          chk("cmd_code", int'(cmd_code), e_code);
        end
      end
      if (ram_wr_en) begin
        cnt_wr++;
        if (exp_wr.size() == 0) chk("ram_wr_en_unexpected", int'(ram_wr_en), 0);
        else begin
          e_wr = exp_wr.pop_front();
          chk("ram_wr_addr", int'(ram_wr_addr), e_wr.addr);
          chk("ram_wr_nibble", int'(ram_wr_nibble), e_wr.nib);
          mem_m[e_wr.addr] = e_wr.nib;
          known[e_wr.addr] = 1'b1;
        end
      end
      if (frame_done || frame_err) begin
        cnt_done += int'(frame_done);
        cnt_err  += int'(frame_err);
        if (exp_end.size() == 0) chk("frame_end_unexpected", int'({frame_done, frame_err}), 0);
        else begin
          e_end = exp_end.pop_front();
          chk("frame_done", int'(frame_done), int'(e_end == 0));
          chk("frame_err", int'(frame_err), e_end);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bit(input bit b, input bit close);
    write = 1'b0;
    data  = b;
    wait_clks($urandom_range(3, 5));
    write = 1'b1;
    if (close) cs = 1'b1;
    wait_clks(6);
  endtask

  task automatic check_status();
    chk("sys_en", int'(sys_en), m_sys);
    chk("led_on", int'(led_on), m_led);
    chk("blink_on", int'(blink_on), m_blink);
    chk("pwm_level", int'(pwm_level), m_pwm);
  endtask

  task automatic run_frame(input bit close_last);
    int n;
    n = fbits.size();
    model_frame();
    cs = 1'b0;
    wait_clks(5);
    chk("busy_active", int'(busy), 1);
    for (int i = 0; i < n; i++) send_bit(fbits[i], close_last && (i == n - 1));
    if (!(close_last && n > 0)) cs = 1'b1;
    wait_clks(12);
    chk("busy_idle", int'(busy), 0);
    check_status();
    fbits.delete();
  endtask

  task automatic snap();
    b_cmd = cnt_cmd; b_wr = cnt_wr; b_done = cnt_done; b_err = cnt_err;
  endtask

  task automatic read_at(input string name, input int a, input int exp);
    rd_addr = 7'(a);
    wait_clks(3);
    @(negedge clk);
    chk(name, int'(rd_data), exp);
    wait_clks(1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  int tbl[8] = '{'h00, 'h01, 'h02, 'h03, 'h08, 'h09, 'hA0, 'h00};

  initial begin
    wr_t w;
    int  k, ids[6];
    ids = '{0, 1, 2, 3, 6, 7};
    rst = 1'b1; cs = 1'b1; write = 1'b1; data = 1'b0; rd_addr = '0;
    wait_clks(4);
    @(negedge clk);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd_code", int'(cmd_code), 0);
    chk("rst_ram_wr_en", int'(ram_wr_en), 0);
    chk("rst_ram_wr_addr", int'(ram_wr_addr), 0);
    chk("rst_ram_wr_nibble", int'(ram_wr_nibble), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_pulses", int'({frame_done, frame_err}), 0);
    chk("rst_status", int'({sys_en, led_on, blink_on, pwm_level}), 0);
    rst = 1'b0;
    wait_clks(6);

    // SYS_EN command frame
    snap();
    push_bits('b100, 3); push_bits('h01, 8); push_bits(0, 1);
    run_frame(1'b0);
    chk("s1_cmd_code", int'(cmd_code), 'h01);
    chk("s1_cmd_count", cnt_cmd - b_cmd, 1);
    chk("s1_done_count", cnt_done - b_done, 1);
`ifdef HT1632_RX_STATUS_EN
    chk("s1_sys_en", int'(sys_en), 1);
`endif

    // Full RAM fill from address 0
    snap();
    rd_addr = 7'd95;
    push_bits('b101, 3); push_bits(0, 7);
    for (int i = 0; i < 96; i++) push_bits(i % 16, 4);
    run_frame(1'b0);
    chk("s2_wr_count", cnt_wr - b_wr, 96);
    chk("s2_done_count", cnt_done - b_done, 1);
    read_at("s2_rd95", 95, 'hF);

    // Pointer wrap 94,95,0
    snap();
    push_bits('b101, 3); push_bits(94, 7);
    push_bits('hA, 4); push_bits('hB, 4); push_bits('hC, 4);
    run_frame(1'b1);
    chk("s3_wr_count", cnt_wr - b_wr, 3);
    read_at("s3_rd0", 0, 'hC);
    read_at("s3_rd94", 94, 'hA);

    // Bad ID
    snap();
    push_bits('b110, 3); push_bits($urandom_range(0, 'hFFFFF), 20);
    run_frame(1'b0);
    chk("s4_err_count", cnt_err - b_err, 1);
    chk("s4_cmd_count", cnt_cmd - b_cmd, 0);
    chk("s4_wr_count", cnt_wr - b_wr, 0);

    // Chained commands
    snap();
    push_bits('b100, 3);
    push_bits('h01, 8); push_bits(1, 1);
    push_bits('h03, 8); push_bits(0, 1);
    push_bits('hAF, 8); push_bits(1, 1);
    run_frame(1'b0);
    chk("s5_cmd_count", cnt_cmd - b_cmd, 3);
    chk("s5_cmd_code", int'(cmd_code), 'hAF);
`ifdef HT1632_RX_STATUS_EN
    chk("s5_led_on", int'(led_on), 1);
    chk("s5_pwm", int'(pwm_level), 'hF);
`endif

    // Partial nibble at close
    snap();
    push_bits('b101, 3); push_bits(5, 7); push_bits('b1001, 4); push_bits('b11, 2);
    run_frame(1'b0);
    chk("s6_wr_count", cnt_wr - b_wr, 1);
    chk("s6_err_count", cnt_err - b_err, 1);
    read_at("s6_rd5", 5, 'h9);

    // Reset in the middle of a data field
    snap();
    w.addr = 10; w.nib = 3; exp_wr.push_back(w);
    w.addr = 11; w.nib = 7; exp_wr.push_back(w);
    push_bits('b101, 3); push_bits(10, 7); push_bits('h3, 4); push_bits('h7, 4); push_bits('b10, 2);
    cs = 1'b0;
    wait_clks(5);
    for (int i = 0; i < fbits.size(); i++) send_bit(fbits[i], 1'b0);
    fbits.delete();
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    m_sys = 0; m_led = 0; m_blink = 0; m_pwm = 0;
    chk("s7_busy_after_rst", int'(busy), 0);
    for (int i = 0; i < 12; i++) send_bit(bit'($urandom_range(0, 1)), 1'b0);
    cs = 1'b1;
    wait_clks(12);
    chk("s7_wr_count", cnt_wr - b_wr, 2);
    chk("s7_no_frame_end", (cnt_done - b_done) + (cnt_err - b_err), 0);
    chk("s7_busy", int'(busy), 0);
    check_status();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      rd_addr = 7'($urandom_range(0, 95));
      case ($urandom_range(0, 3))
        0: begin
          push_bits('b100, 3);
          for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
            k = tbl[$urandom_range(0, 7)];
            if (k == 'hA0) k = k + int'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) k = int'($urandom_range(0, 255));
            push_bits(k, 8); push_bits($urandom_range(0, 1), 1);
          end
          if ($urandom_range(0, 3) == 0) push_bits($urandom_range(0, 255), int'($urandom_range(1, 8)));
        end
        1: begin
          push_bits('b101, 3); push_bits($urandom_range(0, 127), 7);
          for (int d = 0; d < int'($urandom_range(0, 8)); d++) push_bits($urandom_range(0, 15), 4);
          if ($urandom_range(0, 3) == 0) push_bits($urandom_range(0, 7), int'($urandom_range(1, 3)));
        end
        2: begin
          push_bits(ids[$urandom_range(0, 5)], 3);
          push_bits($urandom_range(0, 4095), int'($urandom_range(0, 12)));
        end
        default: push_bits($urandom_range(0, 3), int'($urandom_range(0, 2)));
      endcase
      run_frame(bit'($urandom_range(0, 1)));
    end

    wait_clks(10);
    chk("drain_cmd", exp_cmd.size(), 0);
    chk("drain_wr", exp_wr.size(), 0);
    chk("drain_end", exp_end.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ht1632_rx.md
HT1632_RX -- requirements
Module: ht1632_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on cs/write/data.
REQ-002 SHALL have parameter RAM_DEPTH, default 96, nibble entries of display RAM.
REQ-003 SHALL have one clock and synchronous active-high reset: clk input 1, rising-edge system clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have these ports: cs input 1 (active-low chip select, async); write input 1 (serial strobe, data latched on rising edge, async); data input 1 (serial data, async).
REQ-005 SHALL have these command outputs: cmd_valid output 1 (one-clk pulse per decoded command); cmd_code output 8 (command byte, held until next cmd_valid).
REQ-006 SHALL have these RAM-write outputs: ram_wr_en output 1 (one-clk pulse per stored nibble); ram_wr_addr output 7; ram_wr_nibble output 4.
REQ-007 SHALL have these read-port signals: rd_addr input 7; rd_data output 4 (registered, 1-clk latency).
REQ-008 SHALL have these frame-status outputs: busy output 1 (cs low frame active); frame_done output 1 (pulse on clean frame close); frame_err output 1 (pulse on bad ID or aborted partial field).
REQ-009 SHALL have these status outputs: sys_en output 1; led_on output 1; blink_on output 1; pwm_level output 4.

Function
REQ-010 SHALL pass cs, write, data through SYNC_STAGES flops, then detect write rising edge and cs falling/rising edges on synchronized copies.
REQ-011 SHALL sample one bit per write rising edge while synchronized cs=0, MSB-first into shift register.
REQ-012 SHALL use FSM states IDLE, ID, CMD, ADDR, DATA, ERR; cs falling edge IDLE->ID with bit counter cleared.
REQ-013 SHALL decode ID after 3 bits: 100->CMD, 101->ADDR, any other->ERR with frame_err pulse.
REQ-014 SHALL, in CMD, collect 9 bits (8 command + 1 don't-care), then pulse cmd_valid with cmd_code = first 8 bits, 1 clk after 9th bit's edge detection, and remain in CMD for chained commands.
REQ-015 SHALL, in ADDR, collect 7 bits into write pointer, then go to DATA.
REQ-016 SHALL, in DATA, pulse ram_wr_en per 4 bits with the current pointer, then increment the pointer; pointer RAM_DEPTH-1 wraps to 0.
REQ-017 SHALL, for a write address >= RAM_DEPTH, map the address modulo RAM_DEPTH.
REQ-018 SHALL, in ERR, ignore all bits until cs rises.
REQ-019 SHALL, on cs rising edge, return to IDLE; frame_done pulses if no partial field (bit count in current field 0) and state not ERR, else frame_err pulses; a partial nibble/command is discarded, never written.
REQ-020 SHALL, when write rising and cs rising are detected in the same clk, consume the bit first, then apply the close rule.
REQ-021 SHALL ignore write edges while cs high (no state change, no outputs).
REQ-022 SHALL make the RAM read-first: same-cycle read and write at one address returns the old value.
REQ-023 SHALL drive busy high from the clk after cs falling detection to the clk of cs rising detection.

Reset
REQ-024 SHALL, when rst=1 at a clk edge: state IDLE, synchronizers to cs=1/write=1/data=0, all pulses 0, cmd_code 0, ram_wr_addr 0, ram_wr_nibble 0, rd_data 0, busy 0, status outputs 0.
REQ-025 SHALL not clear RAM contents on reset.
REQ-026 SHALL, on reset mid-frame, discard the frame; the receiver resumes only on the next cs falling edge.

Configuration
REQ-027 SHALL, with HT1632_RX_STATUS_EN defined, update status on cmd_valid: 0x00 sys_en=0, 0x01 sys_en=1, 0x02 led_on=0, 0x03 led_on=1, 0x08 blink_on=0, 0x09 blink_on=1, 0xA0-0xAF pwm_level=code[3:0]; other codes leave status unchanged.
REQ-028 SHALL, without HT1632_RX_STATUS_EN, tie sys_en, led_on, blink_on, pwm_level to 0 and leave them out of the status logic.

Structure
REQ-029 SHALL place the ID codes (3'b100, 3'b101), command byte constants, FSM state encoding, and RAM_DEPTH default in shared package ht1632_pkg.
REQ-030 SHALL implement synchronizer plus edge detect in sub-module ht1632_edge_sync, instantiated for cs/write/data.

Verification
REQ-031 SHALL cover this scenario: 12-bit frame 1000_0000_0010 (SYS_EN) -> one cmd_valid, cmd_code=0x01, frame_done=1, sys_en=1 (STATUS_EN).
REQ-032 SHALL cover this scenario: 394-bit frame ID 101, addr 0, 96 nibbles 0x0..0xF repeating -> 96 ram_wr_en pulses, rd_addr=95 gives rd_data=0xF, frame_done.
REQ-033 SHALL cover this scenario: ID 101, addr 94, 3 nibbles A,B,C -> writes at 94, 95, 0; rd_addr=0 gives 0xC.
REQ-034 SHALL cover this scenario: ID 110 then 20 bits -> frame_err once, no cmd_valid, no ram_wr_en.
REQ-035 SHALL cover this scenario: ID 100 chained 0x01, 0x03, 0xAF in one cs-low window -> three cmd_valid pulses, led_on=1, pwm_level=0xF.
REQ-036 SHALL cover this scenario: ID 101, addr 5, 6 data bits then cs high -> one write at 5, frame_err; rst mid-DATA -> no further writes, busy=0.
